// File: rtl/adc_delay_calib.sv
// Per-channel IODELAY calibration: sweeps all 32 taps, finds the widest passing window, programs its centre.
// Optional manual delay path when ADC_DELAY_CALIB_MANUAL_EN is defined.
module adc_delay_calib #(
    parameter int unsigned NCH      = 20,
    parameter int unsigned NDISCARD = 2,
    parameter int unsigned NCMP     = 8,
    parameter int unsigned MIN_WIN  = 4
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                START,
    input  logic [15:0]         PATTERN,
`ifdef ADC_DELAY_CALIB_MANUAL_EN
    input  logic [7:0]          MAN_CHANNEL,
    input  logic [4:0]          MAN_VALUE,
    input  logic                MAN_UPDATE,
`endif
    input  logic [NCH*16-1:0]   DOUT,
    input  logic                DOUT_VALID,
    output logic [7:0]          DELAY_CHANNEL,
    output logic [4:0]          DELAY_VALUE,
    output logic                DELAY_UPDATE,
    output logic                BUSY,
    output logic                DONE,
    output logic [NCH*5-1:0]    TAP_RESULT,
    output logic [NCH-1:0]      FAIL
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned TAP_W  = 5;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned CH_W   = 8;

    typedef enum logic [2:0] {
        IDLE, SET, DISCARD, CHECK, NEXT_TAP, APPLY, NEXT_CH, FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [WORD_W-1:0]   pattern_q, pattern_d;
    logic                pass_q, pass_d;
    logic [TAP_W-1:0]    cur_start_q, cur_start_d, best_start_q, best_start_d;
    logic [LEN_W-1:0]    cur_len_q, cur_len_d, best_len_q, best_len_d;
    logic [CH_W-1:0]     delay_channel_d;
    logic [TAP_W-1:0]    delay_value_d;
    logic                delay_update_d, busy_d, done_d;
    logic [NCH*5-1:0]    tap_result_d;
    logic [NCH-1:0]      fail_d;

    logic [WORD_W-1:0]   cur_word;
    logic [TAP_W-1:0]    ext_start, cand_start, nb_start, final_tap;
    logic [LEN_W-1:0]    ext_len, cand_len, nb_len;
    logic                win_ok;

    // Select the word of the channel under calibration
    always_comb begin
        cur_word = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_q == CH_W'(i)) cur_word = DOUT[WORD_W*i +: WORD_W];
        end
    end

    // Run bookkeeping for the tap just evaluated; a run open at tap 31 is closed here too
    always_comb begin
        ext_len    = pass_q ? LEN_W'(cur_len_q + 6'd1) : '0;
        ext_start  = (pass_q && cur_len_q == '0) ? tap_q : cur_start_q;
        cand_start = pass_q ? ext_start : cur_start_q;
        cand_len   = pass_q ? ext_len   : cur_len_q;
        nb_start   = best_start_q;
        nb_len     = best_len_q;
        if ((!pass_q || tap_q == 5'd31) && cand_len > best_len_q) begin
            nb_start = cand_start;
            nb_len   = cand_len;
        end
        win_ok    = nb_len >= LEN_W'(MIN_WIN);
        final_tap = win_ok ? TAP_W'(LEN_W'(nb_start) + (nb_len >> 1)) : 5'd16;
    end

    always_comb begin
        state_d         = state_q;
        ch_d            = ch_q;
        tap_d           = tap_q;
        cnt_d           = cnt_q;
        pattern_d       = pattern_q;
        pass_d          = pass_q;
        cur_start_d     = cur_start_q;
        cur_len_d       = cur_len_q;
        best_start_d    = best_start_q;
        best_len_d      = best_len_q;
        delay_channel_d = DELAY_CHANNEL;
        delay_value_d   = DELAY_VALUE;
        delay_update_d  = 1'b0;
        done_d          = 1'b0;
        tap_result_d    = TAP_RESULT;
        fail_d          = FAIL;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d         = SET;
                    ch_d            = '0;
                    tap_d           = '0;
                    pattern_d       = PATTERN;
                    tap_result_d    = '0;
                    fail_d          = '0;
                    cur_start_d     = '0;
                    cur_len_d       = '0;
                    best_start_d    = '0;
                    best_len_d      = '0;
                    delay_channel_d = '0;
                    delay_value_d   = '0;
                    delay_update_d  = 1'b1;
                end
`ifdef ADC_DELAY_CALIB_MANUAL_EN
                else if (MAN_UPDATE) begin
                    delay_channel_d = MAN_CHANNEL;
                    delay_value_d   = MAN_VALUE;
                    delay_update_d  = 1'b1;
                end
`endif
            end
            SET: begin
                cnt_d   = '0;
                state_d = (NDISCARD == 0) ? CHECK : DISCARD;
            end
            DISCARD: begin
                if (DOUT_VALID) begin
                    if (cnt_q == 8'(NDISCARD - 1)) begin
                        cnt_d   = '0;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            CHECK: begin
                if (DOUT_VALID) begin
                    if (cur_word != pattern_q) begin
                        pass_d  = 1'b0;
                        state_d = NEXT_TAP;
                    end else if (cnt_q == 8'(NCMP - 1)) begin
                        pass_d  = 1'b1;
                        state_d = NEXT_TAP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            NEXT_TAP: begin
                cur_start_d     = ext_start;
                cur_len_d       = ext_len;
                best_start_d    = nb_start;
                best_len_d      = nb_len;
                delay_channel_d = ch_q;
                delay_update_d  = 1'b1;
                if (tap_q != 5'd31) begin
                    tap_d         = tap_q + 5'd1;
                    delay_value_d = tap_q + 5'd1;
                    state_d       = SET;
                end else begin
                    delay_value_d = final_tap;
                    state_d       = APPLY;
                    for (int unsigned i = 0; i < NCH; i++) begin
                        if (ch_q == CH_W'(i)) begin
                            tap_result_d[TAP_W*i +: TAP_W] = final_tap;
                            fail_d[i]                      = !win_ok;
                        end
                    end
                end
            end
            APPLY: state_d = NEXT_CH;
            NEXT_CH: begin
                if (ch_q != CH_W'(NCH - 1)) begin
                    ch_d            = ch_q + 8'd1;
                    tap_d           = '0;
                    cur_start_d     = '0;
                    cur_len_d       = '0;
                    best_start_d    = '0;
                    best_len_d      = '0;
                    delay_channel_d = ch_q + 8'd1;
                    delay_value_d   = '0;
                    delay_update_d  = 1'b1;
                    state_d         = SET;
                end else begin
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            tap_q         <= '0;
            cnt_q         <= '0;
            pattern_q     <= '0;
            pass_q        <= 1'b0;
            cur_start_q   <= '0;
            cur_len_q     <= '0;
            best_start_q  <= '0;
            best_len_q    <= '0;
            DELAY_CHANNEL <= '0;
            DELAY_VALUE   <= '0;
            DELAY_UPDATE  <= 1'b0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            TAP_RESULT    <= '0;
            FAIL          <= '0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            tap_q         <= tap_d;
            cnt_q         <= cnt_d;
            pattern_q     <= pattern_d;
            pass_q        <= pass_d;
            cur_start_q   <= cur_start_d;
            cur_len_q     <= cur_len_d;
            best_start_q  <= best_start_d;
            best_len_q    <= best_len_d;
            DELAY_CHANNEL <= delay_channel_d;
            DELAY_VALUE   <= delay_value_d;
            DELAY_UPDATE  <= delay_update_d;
            BUSY          <= busy_d;
            DONE          <= done_d;
            TAP_RESULT    <= tap_result_d;
            FAIL          <= fail_d;
        end
    end

endmodule

// File: tb/tb_adc_delay_calib.sv
// Scoreboard bench for adc_delay_calib: a per-tap pass-mask ADC model feeds DOUT, expected
// delay updates and final results are queued at start and popped as the DUT produces them.
module tb_adc_delay_calib;

    localparam int NCH = 2;
    localparam int MIN_WIN = 4;
    localparam logic [15:0] PAT = 16'hA5C3;

    typedef struct packed {
        logic [7:0] ch;
        logic [4:0] val;
    } upd_t;

    typedef struct packed {
        logic [NCH*5-1:0] taps;
        logic [NCH-1:0]   fail;
    } res_t;

    logic               CLK;
    logic               RESET_N;
    logic               START;
    logic [15:0]        PATTERN;
    logic [NCH*16-1:0]  DOUT;
    logic               DOUT_VALID;
    logic [7:0]         DELAY_CHANNEL;
    logic [4:0]         DELAY_VALUE;
    logic               DELAY_UPDATE;
    logic               BUSY;
    logic               DONE;
    logic [NCH*5-1:0]   TAP_RESULT;
    logic [NCH-1:0]     FAIL;
`ifdef ADC_DELAY_CALIB_MANUAL_EN
    logic [7:0]         MAN_CHANNEL;
    logic [4:0]         MAN_VALUE;
    logic               MAN_UPDATE;
`endif

    adc_delay_calib #(.NCH(NCH), .NDISCARD(2), .NCMP(8), .MIN_WIN(MIN_WIN)) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .START         (START),
        .PATTERN       (PATTERN),
`ifdef ADC_DELAY_CALIB_MANUAL_EN
        .MAN_CHANNEL   (MAN_CHANNEL),
        .MAN_VALUE     (MAN_VALUE),
        .MAN_UPDATE    (MAN_UPDATE),
`endif
        .DOUT          (DOUT),
        .DOUT_VALID    (DOUT_VALID),
        .DELAY_CHANNEL (DELAY_CHANNEL),
        .DELAY_VALUE   (DELAY_VALUE),
        .DELAY_UPDATE  (DELAY_UPDATE),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .TAP_RESULT    (TAP_RESULT),
        .FAIL          (FAIL)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          upd_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] mask [NCH];
    logic [4:0]  hw_tap [NCH];
    upd_t        upd_q[$];
    res_t        res_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference window search over a pass mask: returns {fail, tap}
    function automatic logic [5:0] exp_tap(input logic [31:0] m);
        int bs = 0;
        int bl = 0;
        int s  = 0;
        int l  = 0;
        for (int t = 0; t < 32; t++) begin
            if (m[t]) begin
                if (l == 0) s = t;
                l++;
                if (l > bl) begin
                    bl = l;
                    bs = s;
                end
            end else begin
                l = 0;
            end
        end
        if (bl >= MIN_WIN) return {1'b0, 5'(bs + bl / 2)};
        return {1'b1, 5'd16};
    endfunction

    // Monitor + ADC/IODELAY model, all on the falling edge
    initial begin
        int   vcnt = 0;
        upd_t got, exp_u;
        res_t exp_r;
        DOUT = '0;
        DOUT_VALID = 1'b0;
        for (int c = 0; c < NCH; c++) hw_tap[c] = 5'd0;
        forever begin
            @(negedge CLK);
            if (DELAY_UPDATE) begin
                upd_cnt++;
                got = '{ch: DELAY_CHANNEL, val: DELAY_VALUE};
                n_cmp++;
                if (upd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL upd_seq: unexpected update ch=%0d val=%0d, none required", got.ch, got.val);
                end else begin
                    exp_u = upd_q.pop_front();
                    if (got !== exp_u) begin
                        n_err++;
                        $display("FAIL upd_seq: got ch=%0d val=%0d, required ch=%0d val=%0d",
                                 got.ch, got.val, exp_u.ch, exp_u.val);
                    end
                end
                if (int'(DELAY_CHANNEL) < NCH) hw_tap[DELAY_CHANNEL] = DELAY_VALUE;
            end
            if (DONE) begin
                done_cnt++;
                n_cmp++;
                if (res_q.size() == 0) begin
                    n_err++;
                    $display("FAIL done_result: unexpected DONE");
                end else begin
                    exp_r = res_q.pop_front();
                    if (TAP_RESULT !== exp_r.taps || FAIL !== exp_r.fail) begin
                        n_err++;
                        $display("FAIL done_result: got taps=%h fail=%b, required taps=%h fail=%b",
                                 TAP_RESULT, FAIL, exp_r.taps, exp_r.fail);
                    end
                end
            end
            vcnt = (vcnt + 1) % 3;
            DOUT_VALID = (vcnt == 0);
            for (int c = 0; c < NCH; c++)
                DOUT[16*c +: 16] = mask[c][hw_tap[c]] ? PAT : (PAT ^ 16'h0100);
        end
    end

    // Queue expected updates/results for the masks, then pulse START
    task automatic start_run(input logic [31:0] m0, input logic [31:0] m1);
        res_t r;
        logic [5:0] e;
        mask[0] = m0;
        mask[1] = m1;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int t = 0; t < 32; t++) upd_q.push_back('{ch: 8'(c), val: 5'(t)});
            e = exp_tap(mask[c]);
            upd_q.push_back('{ch: 8'(c), val: e[4:0]});
            r.taps[5*c +: 5] = e[4:0];
            r.fail[c] = e[5];
        end
        res_q.push_back(r);
        upd_cnt = 0;
        done_cnt = 0;
        @(negedge CLK);
        START = 1'b1;
        PATTERN = PAT;
        @(negedge CLK);
        START = 1'b0;
        PATTERN = 16'h0000;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge CLK);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({DELAY_CHANNEL, DELAY_VALUE, DELAY_UPDATE, BUSY, DONE, TAP_RESULT, FAIL} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ch=%0d val=%0d upd=%b busy=%b done=%b taps=%h fail=%b, required all 0",
                     DELAY_CHANNEL, DELAY_VALUE, DELAY_UPDATE, BUSY, DONE, TAP_RESULT, FAIL);
        end
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (BUSY !== 1'b0 || DELAY_UPDATE !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b upd=%b, required 0 0", BUSY, DELAY_UPDATE);
        end
    endtask

    task automatic check_run_end(input string name);
        bit ok;
        wait_done(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_timeout: DONE not seen, required within budget", name);
        end
        n_cmp++;
        if (upd_cnt !== 66) begin
            n_err++;
            $display("FAIL %s_upd_count: got %0d, required 66", name, upd_cnt);
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt);
        end
        n_cmp++;
        if (upd_q.size() != 0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain: got pending=%0d busy=%b, required 0 0", name, upd_q.size(), BUSY);
        end
        upd_q.delete();
        res_q.delete();
    endtask

    task automatic test_basic;
        start_run(32'h000F_FC00, 32'hFFFF_FFFF);
        n_cmp++;
        if (BUSY !== 1'b1 || DELAY_UPDATE !== 1'b1) begin
            n_err++;
            $display("FAIL start_latency: got busy=%b upd=%b, required 1 1", BUSY, DELAY_UPDATE);
        end
        repeat (20) @(negedge CLK);
        START = 1'b1;
        PATTERN = 16'h1234;
        @(negedge CLK);
        START = 1'b0;
        check_run_end("basic");
        n_cmp++;
        if (TAP_RESULT !== {5'd16, 5'd15} || FAIL !== 2'b00) begin
            n_err++;
            $display("FAIL basic_final: got taps=%h fail=%b, required taps=%h fail=00",
                     TAP_RESULT, FAIL, {5'd16, 5'd15});
        end
    endtask

    task automatic test_two_windows;
        start_run(32'h01F0_0038, 32'hFFFF_FFFF);
        check_run_end("two_win");
        n_cmp++;
        if (TAP_RESULT[4:0] !== 5'd22) begin
            n_err++;
            $display("FAIL two_win_tap: got %0d, required 22", TAP_RESULT[4:0]);
        end
    endtask

    task automatic test_tie;
        start_run(32'h0003_F0FC, 32'hFFFF_FFFF);
        check_run_end("tie");
        n_cmp++;
        if (TAP_RESULT[4:0] !== 5'd5) begin
            n_err++;
            $display("FAIL tie_tap: got %0d, required 5", TAP_RESULT[4:0]);
        end
    endtask

    task automatic test_min_win;
        start_run(32'h0000_0700, 32'h0000_0000);
        check_run_end("min_win");
        n_cmp++;
        if (TAP_RESULT !== {5'd16, 5'd16} || FAIL !== 2'b11) begin
            n_err++;
            $display("FAIL min_win_final: got taps=%h fail=%b, required taps=%h fail=11",
                     TAP_RESULT, FAIL, {5'd16, 5'd16});
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        start_run(32'h000F_FC00, 32'hFFFF_FFFF);
        seen = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge CLK);
            if (DELAY_UPDATE && DELAY_CHANNEL == 8'd1 && DELAY_VALUE == 5'd5) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL reset_mid_reach: ch1 tap5 update not seen, required");
        end
        repeat (12) @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        upd_q.delete();
        res_q.delete();
        n_cmp++;
        if ({DELAY_CHANNEL, DELAY_VALUE, DELAY_UPDATE, BUSY, DONE, TAP_RESULT, FAIL} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got ch=%0d val=%0d upd=%b busy=%b done=%b taps=%h fail=%b, required all 0",
                     DELAY_CHANNEL, DELAY_VALUE, DELAY_UPDATE, BUSY, DONE, TAP_RESULT, FAIL);
        end
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (20) @(negedge CLK);
        n_cmp++;
        if (done_cnt !== 0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_done: got done=%0d busy=%b, required 0 0", done_cnt, BUSY);
        end
    endtask

    task automatic test_back_to_back;
        start_run(32'h00FF_FF00, 32'h0000_FFF0);
        check_run_end("after_reset");
        n_cmp++;
        if (TAP_RESULT !== {5'd10, 5'd16} || FAIL !== 2'b00) begin
            n_err++;
            $display("FAIL after_reset_final: got taps=%h fail=%b, required taps=%h fail=00",
                     TAP_RESULT, FAIL, {5'd10, 5'd16});
        end
    endtask

`ifdef ADC_DELAY_CALIB_MANUAL_EN
    task automatic test_manual;
        upd_q.push_back('{ch: 8'd7, val: 5'd9});
        upd_cnt = 0;
        @(negedge CLK);
        MAN_CHANNEL = 8'd7;
        MAN_VALUE = 5'd9;
        MAN_UPDATE = 1'b1;
        @(negedge CLK);
        MAN_UPDATE = 1'b0;
        n_cmp++;
        if (DELAY_UPDATE !== 1'b1 || DELAY_CHANNEL !== 8'd7 || DELAY_VALUE !== 5'd9) begin
            n_err++;
            $display("FAIL manual_idle: got upd=%b ch=%0d val=%0d, required 1 7 9",
                     DELAY_UPDATE, DELAY_CHANNEL, DELAY_VALUE);
        end
        repeat (3) @(negedge CLK);
        start_run(32'h000F_FC00, 32'hFFFF_FFFF);
        repeat (30) @(negedge CLK);
        MAN_UPDATE = 1'b1;
        @(negedge CLK);
        MAN_UPDATE = 1'b0;
        check_run_end("manual_busy");
    endtask
`endif

    initial begin
        RESET_N = 1'b0;
        START = 1'b0;
        PATTERN = 16'h0000;
        mask[0] = '0;
        mask[1] = '0;
`ifdef ADC_DELAY_CALIB_MANUAL_EN
        MAN_CHANNEL = '0;
        MAN_VALUE = '0;
        MAN_UPDATE = 1'b0;
`endif
        test_reset();
        test_basic();
        test_two_windows();
        test_tie();
        test_min_win();
        test_reset_mid();
        test_back_to_back();
`ifdef ADC_DELAY_CALIB_MANUAL_EN
        test_manual();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
